// File: rtl/t02_wb_ram_bridge.sv
// rtl/t02_wb_ram_bridge.sv - core RAM request port to Wishbone-classic master bridge
//
// Converts one single-word core request (Ren/Wen level) into one Wishbone
// classic transaction. Only one transaction is ever outstanding.
//
// Optional feature macro: T02_BUS_TIMEOUT_EN
//   Defined   : ack wait is bounded by TIMEOUT_CYCLES BUS cycles. An expired
//               wait abandons the cycle, returns 32'hDEAD_BEEF on a read and
//               sets the sticky bus_err_o flag.
//   Undefined : BUS waits for ack indefinitely and bus_err_o does not exist.
//
// Parameters:
//   TIMEOUT_CYCLES - ack wait limit in BUS cycles (timeout build only)
//   SEL_MASK       - byte selects driven for every transaction
//
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   ramaddr, ramstore        - core byte address / write data
//   Ren, Wen                 - core read / write request (level)
//   ramload                  - read data returned to the core
//   busy_o                   - request not yet complete (combinational)
//   wb_cyc_o .. wb_sel_o     - Wishbone master outputs
//   wb_dat_i, wb_ack_i       - Wishbone slave read data / acknowledge
//   bus_err_o                - sticky timeout flag (timeout build only)

module t02_wb_ram_bridge #(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [3:0] SEL_MASK       = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef T02_BUS_TIMEOUT_EN
    output logic        bus_err_o,
`endif
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        Ren,
    input  logic        Wen,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t state;
    state_t state_next;

    logic   req;
    logic   start;
    logic   ack_done;
    logic   timeout_hit;

    assign req      = Ren | Wen;
    assign start    = (state == IDLE) && req;
    assign ack_done = (state == BUS) && wb_ack_i;

`ifdef T02_BUS_TIMEOUT_EN
    // At least 8 bits, wider if the limit needs it.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt;

    // The counter holds the number of ack-less BUS cycles already finished,
    // so the limit is reached on the edge closing the TIMEOUT_CYCLES-th one.
    // An ack on that same edge takes priority and completes normally.
    assign timeout_hit = (state == BUS) && !wb_ack_i &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            bus_err_o <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= '0;
            end else if ((state == BUS) && !wb_ack_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                bus_err_o <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;

    // The limit only matters in the timeout build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (ack_done || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Requests held over from the finished transaction are
                // not accepted here; the core re-arms after seeing busy_o=0.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset also forces busy low so the core sees the aborted request
    // immediately, in step with the asynchronous drop of cyc/stb.
    assign busy_o = !rst && (start || (state == BUS));

    // Wishbone outputs and read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            ramload  <= '0;
        end else begin
            if (start) begin
                // Wen wins when both are raised: the cycle becomes a write.
                wb_adr_o <= ramaddr;
                wb_dat_o <= ramstore;
                wb_we_o  <= Wen;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= SEL_MASK;
            end else if (ack_done || timeout_hit) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
                if (!wb_we_o) begin
                    ramload <= ack_done ? wb_dat_i : TIMEOUT_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_t02_wb_ram_bridge.sv
// tb/tb_t02_wb_ram_bridge.sv - directed self-checking bench for t02_wb_ram_bridge

module tb_t02_wb_ram_bridge;

`ifdef T02_BUS_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ramaddr = '0;
    logic [31:0] ramstore = '0;
    logic        Ren = 1'b0;
    logic        Wen = 1'b0;
    logic [31:0] ramload;
    logic        busy_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
`ifdef T02_BUS_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    t02_wb_ram_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .SEL_MASK      (4'hF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef T02_BUS_TIMEOUT_EN
        .bus_err_o(bus_err_o),
`endif
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .Ren      (Ren),
        .Wen      (Wen),
        .ramload  (ramload),
        .busy_o   (busy_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_ramload", ramload, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        step();

        // ack outside BUS is ignored
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_FFFF;
        step();
        chk("stray_ack_ramload", ramload, 0);
        chk("stray_ack_busy", busy_o, 0);
        wb_ack_i = 1'b0;

        // Read, zero-wait slave
        Ren = 1'b1;
        ramaddr = 32'h3300_0010;
        #1;
        chk("rd_busy_req", busy_o, 1);
        step();
        chk("rd_cyc", wb_cyc_o, 1);
        chk("rd_stb", wb_stb_o, 1);
        chk("rd_we", wb_we_o, 0);
        chk("rd_adr", wb_adr_o, 32'h3300_0010);
        chk("rd_sel", wb_sel_o, 4'hF);
        chk("rd_busy_bus", busy_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        step();
        chk("rd_busy_done", busy_o, 0);
        chk("rd_ramload", ramload, 32'h1234_5678);
        chk("rd_cyc_done", wb_cyc_o, 0);
        chk("rd_sel_done", wb_sel_o, 0);
        Ren = 1'b0;
        wb_ack_i = 1'b0;
        step();
        chk("rd_idle_busy", busy_o, 0);

        // Write, 3 wait states, address changed mid-BUS
        Wen = 1'b1;
        ramaddr = 32'h3300_0020;
        ramstore = 32'hCAFE_F00D;
        step();
        ramaddr = 32'h0;
        ramstore = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_cyc", wb_cyc_o, 1);
            chk("wr_stb", wb_stb_o, 1);
            chk("wr_we", wb_we_o, 1);
            chk("wr_dat", wb_dat_o, 32'hCAFE_F00D);
            chk("wr_adr_hold", wb_adr_o, 32'h3300_0020);
            chk("wr_sel", wb_sel_o, 4'hF);
            chk("wr_busy", busy_o, 1);
            if (i == 3) wb_ack_i = 1'b1;
            step();
        end
        chk("wr_busy_done", busy_o, 0);
        chk("wr_ramload_kept", ramload, 32'h1234_5678);
        chk("wr_we_done", wb_we_o, 0);
        Wen = 1'b0;
        wb_ack_i = 1'b0;
        step();

        // Ren and Wen together -> write
        Ren = 1'b1;
        Wen = 1'b1;
        ramaddr = 32'h3300_0030;
        ramstore = 32'h0000_00AA;
        step();
        chk("both_we", wb_we_o, 1);
        chk("both_dat", wb_dat_o, 32'h0000_00AA);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_5555;
        step();
        chk("both_ramload_kept", ramload, 32'h1234_5678);
        Ren = 1'b0;
        Wen = 1'b0;
        wb_ack_i = 1'b0;
        step();

        // Core holds Ren after ack: one transaction, second after DONE
        Ren = 1'b1;
        ramaddr = 32'h3300_0040;
        step();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1111_1111;
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("hold_done_busy", busy_o, 0);
        chk("hold_done_cyc", wb_cyc_o, 0);
        chk("hold_ramload1", ramload, 32'h1111_1111);
        step();
        chk("hold_idle_cyc", wb_cyc_o, 0);
        chk("hold_idle_busy", busy_o, 1);
        step();
        chk("hold_bus2_cyc", wb_cyc_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h2222_2222;
        step();
        chk("hold_ramload2", ramload, 32'h2222_2222);
        Ren = 1'b0;
        wb_ack_i = 1'b0;
        step();

        // Reset during BUS
        Ren = 1'b1;
        ramaddr = 32'h3300_0050;
        step();
        chk("rstbus_cyc_pre", wb_cyc_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstbus_cyc", wb_cyc_o, 0);
        chk("rstbus_stb", wb_stb_o, 0);
        chk("rstbus_busy", busy_o, 0);
        Ren = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("rstbus_after_cyc", wb_cyc_o, 0);

`ifdef T02_BUS_TIMEOUT_EN
        // Ack on the timeout cycle wins
        Ren = 1'b1;
        ramaddr = 32'h3300_0060;
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_ack_busy_last", busy_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5A5A_5A5A;
        step();
        chk("tmo_ack_ramload", ramload, 32'h5A5A_5A5A);
        chk("tmo_ack_err", bus_err_o, 0);
        Ren = 1'b0;
        wb_ack_i = 1'b0;
        step();

        // No ack: timeout after TMO BUS cycles
        Ren = 1'b1;
        ramaddr = 32'h3300_0070;
        step();
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_busy", busy_o, 1);
            chk("tmo_err_pre", bus_err_o, 0);
            step();
        end
        chk("tmo_busy_done", busy_o, 0);
        chk("tmo_ramload", ramload, 32'hDEAD_BEEF);
        chk("tmo_err", bus_err_o, 1);
        chk("tmo_cyc", wb_cyc_o, 0);
        Ren = 1'b0;
        step();
        step();
        chk("tmo_err_sticky", bus_err_o, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/t02_wb_ram_bridge.md
Name: t02_wb_ram_bridge

Overview:
- Sits directly downstream of the team 02 core's RAM request port (ramaddr/ramstore/Ren/Wen in, ramload/busy_o out).
- Converts each single-word core request into one Wishbone-classic master transaction on the shared bus.
- Returns read data and the busy handshake the core's request unit already expects.
- Exactly one transaction is outstanding at a time; no pipelining.

Parameters:
- TIMEOUT_CYCLES, 255: ack wait limit in cycles; used only when T02_BUS_TIMEOUT_EN is defined.
- SEL_MASK, 4'hF: byte-select value driven on wb_sel_o for every transaction.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ramaddr  input  32  core byte address.
- ramstore  input  32  core write data.
- Ren  input  1  core read request, level.
- Wen  input  1  core write request, level.
- ramload  output  32  read data returned to the core.
- busy_o  output  1  high while the core's request is not yet complete.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  Wishbone write enable.
- wb_adr_o  output  32  Wishbone address.
- wb_dat_o  output  32  Wishbone write data.
- wb_sel_o  output  4  Wishbone byte selects.
- wb_dat_i  input  32  Wishbone read data.
- wb_ack_i  input  1  Wishbone acknowledge.
- bus_err_o  output  1  sticky timeout flag; only present with T02_BUS_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; all wb_* outputs 0; ramload=0; bus_err_o=0; timeout counter=0.
- States: IDLE, BUS, DONE.
- IDLE:
  - If Ren|Wen, latch ramaddr into wb_adr_o and ramstore into wb_dat_o.
  - Set wb_we_o=Wen; Wen has priority when Ren and Wen are both high, and the cycle is a write.
  - Assert wb_cyc_o=wb_stb_o=1 and wb_sel_o=SEL_MASK on the next edge; go to BUS.
- BUS:
  - Hold cyc/stb/we/adr/dat/sel stable until wb_ack_i=1.
  - On the ack edge: deassert cyc/stb/we and set sel=0. For a read, latch wb_dat_i into ramload. Go to DONE.
  - A write leaves ramload unchanged.
- DONE: one cycle only. Requests are ignored, then go to IDLE. The core must drop or replace its request on seeing busy_o=0.
- busy_o is combinational: 1 in IDLE when Ren|Wen, 1 in BUS, 0 in DONE, 0 in IDLE with no request. The core therefore never sees busy_o=0 on the cycle it first raises a request.
- Latency: request seen at edge N → cyc/stb high after edge N. Ack sampled at edge N+k → busy_o low during cycle N+k+1 (DONE), with ramload already valid. A zero-wait slave (ack in the first BUS cycle) gives k=1.
- Changes to ramaddr, ramstore, Ren or Wen while in BUS are ignored; the latched values are used.
- wb_ack_i outside BUS is ignored.
- Reset asserted mid-transaction drops cyc/stb immediately (asynchronous). No retry after reset.

Optional Feature:
- Macro: T02_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the transaction is abandoned: cyc/stb drop, go to DONE, a read returns ramload=32'hDEAD_BEEF, and bus_err_o sets.
  - bus_err_o stays set until reset.
  - An ack arriving on the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter and no bus_err_o port; BUS waits for ack indefinitely.

Test Plan:
- Read, zero-wait slave:
  - Stimulus: Ren=1, ramaddr=0x3300_0010; slave acks in the first BUS cycle with wb_dat_i=0x1234_5678.
  - Required: wb_adr_o=0x3300_0010 and we=0; busy_o is 1 for 2 cycles and then 0; ramload=0x1234_5678 in DONE.
- Write, 3 wait states:
  - Stimulus: Wen=1, ramaddr=0x3300_0020, ramstore=0xCAFE_F00D; ack after 3 stall cycles.
  - Required: cyc/stb/we/dat stable for 4 BUS cycles, sel=4'hF; ramload unchanged.
- Ren=Wen=1 with ramstore=0x0000_00AA → a write transaction is issued (we=1), dat=0x0000_00AA.
- ramaddr changed to 0x0 mid-BUS → wb_adr_o holds the original address.
- After ack, the core keeps Ren=1 → exactly one transaction completes; a second starts after DONE.
- Reset pulsed during BUS → cyc/stb/busy_o go to 0 asynchronously.
- With T02_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no ack:
  - Required: busy_o falls after 8 BUS cycles plus DONE; ramload=0xDEAD_BEEF; bus_err_o=1 and sticky.
- With T02_BUS_TIMEOUT_EN, ack on the same cycle as the timeout → normal data returned, bus_err_o=0.
